div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one 8÷8 divider instance among N_REQ requesters.
- Arbitrates round-robin, latches the winner's operands and drives the divider's start/A/B.
- Waits for the divider's done, captures Q/R/div_zero, and returns them to the winning requester with a one-cycle response pulse.
- Sits beside the divider top in the arithmetic cluster; the divider's clk, start, A, B, Q, R, done and div_zero connect directly to the div_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum WAIT cycles before the watchdog aborts the operation (must be ≥ worst-case divider latency + 2).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request level.
- req_a  input  8*N_REQ  dividend, requester i at bits [8i+7:8i].
- req_b  input  8*N_REQ  divisor, same packing.
- gnt  output  N_REQ  one-hot grant; operands have been captured.
- rsp_valid  output  N_REQ  one-hot, one-cycle response pulse.
- rsp_q  output  8  quotient, shared; valid when any rsp_valid bit is set.
- rsp_r  output  8  remainder, shared.
- rsp_dz  output  1  divide-by-zero flag, shared.
- rsp_err  output  1  watchdog abort flag, shared.
- div_start  output  1  one-cycle start pulse to the divider.
- div_a  output  8  latched dividend.
- div_b  output  8  latched divisor.
- div_q  input  8  divider quotient.
- div_r  input  8  divider remainder.
- div_done  input  1  divider completion flag (level or pulse).
- div_zero  input  1  divider divide-by-zero flag.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; RR pointer = 0.
  - All outputs and latched operand/result registers go to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick winner k = first set bit searching from ptr upward, with wrap-around.
  - On that edge: latch req_a[k] and req_b[k] into div_a and div_b, register k, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle): gnt[k]=1 and div_start=1; go to WAIT; clear the watchdog counter.
- WAIT:
  - div_done is ignored during ISSUE and during the first WAIT cycle, so a stale level-done from the previous operation is not accepted.
  - From the second WAIT cycle on, the first div_done=1 captures: rsp_q=div_q, rsp_r=div_r, rsp_dz=div_zero, rsp_err=0; go to RESP.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT: rsp_q=0xFF, rsp_r=div_a, rsp_dz=0, rsp_err=1; go to RESP.
- RESP (one cycle): rsp_valid[k]=1; ptr = (k+1) mod N_REQ; go to IDLE.
- rsp_q, rsp_r, rsp_dz and rsp_err hold their values until the next capture.
- Requester protocol:
  - Hold req and operands stable until gnt.
  - After gnt, req may drop; operands are no longer used.
  - req still high in the cycle after rsp_valid is a new request.
- Latency: req sampled in IDLE → gnt 1 cycle later → rsp_valid at divider latency + 3 cycles after the sampling edge.
- Simultaneous requests: strict round-robin. The requester just served has lowest priority next arbitration.
- Requests arriving while busy are held off, not dropped; no queueing beyond the req level.
- A req bit dropping before gnt is allowed; arbitration uses the req value sampled in IDLE only.
- Reset mid-operation: aborts immediately with no response pulse. The divider is reset by the same system reset at integration.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a winner with req_b[k]==0 skips ISSUE/WAIT: gnt[k] is asserted during a one-cycle ISSUE with div_start=0, then RESP.
  - Response: rsp_q=0xFF, rsp_r=req_a[k], rsp_dz=1, rsp_err=0.
  - Total req→rsp_valid = 2 cycles.
- Not defined: zero divisors go through the divider like any other operand; rsp_dz reflects div_zero.

Decomposition:
- Shared header div_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - the DIV_W=8 operand width;
  - the saturation constant 0xFF.
- One sub-module: rr_arbiter.
  - Combinational; inputs req and ptr, outputs one-hot winner and index.
  - Reused later by other shared-arithmetic blocks.

Test Plan:
- Single requester: req[0]=1, A=100, B=7 → gnt[0] after 1 cycle, div_start 1 pulse, rsp_valid[0] with Q=14, R=2, dz=0, err=0.
- Contention: req=4'b1111 held continuously, distinct operands per requester → grants in order 0,1,2,3,0; each rsp_valid goes to the matching requester with correct Q/R.
- Divide by zero, macro off: A=9, B=0 → divider runs, rsp_dz=1, Q/R as the divider reports. Macro on: rsp_valid 2 cycles after req, Q=0xFF, R=9, dz=1, div_start never asserted.
- Watchdog: divider model never raises done → rsp_valid after TIMEOUT WAIT cycles with err=1, Q=0xFF, R=A; next request is then served normally.
- Reset mid-WAIT: assert reset=0 during WAIT → busy, gnt and rsp_valid are 0 immediately; after release no stray rsp_valid, and ptr restarts at 0.
- Level done: divider holds done high after finishing; back-to-back requests 1 then 2 → requester 2 receives its own result, not the stale one.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: operand width, saturation
// constant, FSM state encoding and the round-robin pointer helper.
package div_arbiter_pkg;

  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_SAT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Requester after idx, wrapping at n; the one just served drops to lowest priority.
  function automatic int rr_next(input int idx, input int n);
    if (idx >= n - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider-side signal bundle of the divider arbiter.
// master: the arbiter's view; slave: requesters plus the divider.
interface div_arbiter_if #(
  parameter int N_REQ = 4
);
  import div_arbiter_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [DIV_W*N_REQ-1:0] req_a;
  logic [DIV_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [DIV_W-1:0]       rsp_q;
  logic [DIV_W-1:0]       rsp_r;
  logic                   rsp_dz;
  logic                   rsp_err;
  logic                   div_start;
  logic [DIV_W-1:0]       div_a;
  logic [DIV_W-1:0]       div_b;
  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       div_r;
  logic                   div_done;
  logic                   div_zero;
  logic                   busy;

  modport master (
    input  req, req_a, req_b, div_q, div_r, div_done, div_zero,
    output gnt, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_err,
           div_start, div_a, div_b, busy
  );

  modport slave (
    output req, req_a, req_b, div_q, div_r, div_done, div_zero,
    input  gnt, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_err,
           div_start, div_a, div_b, busy
  );

endinterface

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around. Kept generic so other shared-arithmetic blocks can reuse it.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  // Rotating scan from ptr; the first hit claims the grant, later hits are masked.
  always_comb begin
    int   raw_j;
    int   j;
    logic hit;
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    raw_j      = 0;
    j          = 0;
    hit        = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      raw_j         = int'(ptr) + i;
      j             = (raw_j >= N_REQ) ? (raw_j - N_REQ) : raw_j;
      hit           = req[j] & ~win_valid;
      win_onehot[j] = win_onehot[j] | hit;
      win_idx       = hit ? IDX_W'(j) : win_idx;
      win_valid     = win_valid | hit;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one 8/8 divider among N_REQ requesters: round-robin arbitration,
// operand latch, divider start, done capture with watchdog, one-cycle response.
// Optional feature macro DIV_ZERO_BYPASS_EN: zero divisors are answered
// directly without starting the divider.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         reset,
  div_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_e           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] idx_r;
  logic [N_REQ-1:0] hot_r;
  logic [WD_W-1:0]  wdog_r;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] rsp_valid_r;
  logic [DIV_W-1:0] rsp_q_r;
  logic [DIV_W-1:0] rsp_r_r;
  logic             rsp_dz_r;
  logic             rsp_err_r;
  logic             div_start_r;
  logic [DIV_W-1:0] div_a_r;
  logic [DIV_W-1:0] div_b_r;
  logic             busy_r;
`ifdef DIV_ZERO_BYPASS_EN
  logic             byp_r;
`endif

  logic [N_REQ-1:0] win_onehot_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_valid_s;
  logic [DIV_W-1:0] sel_a_s;
  logic [DIV_W-1:0] sel_b_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (bus.req),
    .ptr        (ptr_r),
    .win_onehot (win_onehot_s),
    .win_idx    (win_idx_s),
    .win_valid  (win_valid_s)
  );

  assign sel_a_s = bus.req_a[int'(win_idx_s)*DIV_W +: DIV_W];
  assign sel_b_s = bus.req_b[int'(win_idx_s)*DIV_W +: DIV_W];

  // Arbitration / issue / wait / respond sequencing with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      idx_r       <= '0;
      hot_r       <= '0;
      wdog_r      <= '0;
      gnt_r       <= '0;
      rsp_valid_r <= '0;
      rsp_q_r     <= '0;
      rsp_r_r     <= '0;
      rsp_dz_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
      div_start_r <= 1'b0;
      div_a_r     <= '0;
      div_b_r     <= '0;
      busy_r      <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      byp_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= '0;
          if (win_valid_s) begin
            div_a_r <= sel_a_s;
            div_b_r <= sel_b_s;
            idx_r   <= win_idx_s;
            hot_r   <= win_onehot_s;
            gnt_r   <= win_onehot_s;
            busy_r  <= 1'b1;
            state_r <= ST_ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
            // A zero divisor never reaches the divider.
            div_start_r <= (sel_b_s != '0);
            byp_r       <= (sel_b_s == '0);
`else
            div_start_r <= 1'b1;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          gnt_r       <= '0;
          div_start_r <= 1'b0;
          wdog_r      <= '0;
`ifdef DIV_ZERO_BYPASS_EN
          if (byp_r) begin
            rsp_q_r     <= DIV_SAT;
            rsp_r_r     <= div_a_r;
            rsp_dz_r    <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= hot_r;
            state_r     <= ST_RESP;
          end else begin
            state_r     <= ST_WAIT;
          end
`else
          state_r <= ST_WAIT;
`endif
        end

        ST_WAIT: begin
          // wdog_r == 0 marks the first WAIT cycle, where a level done may
          // still belong to the previous operation.
          if ((wdog_r != '0) && bus.div_done) begin
            rsp_q_r     <= bus.div_q;
            rsp_r_r     <= bus.div_r;
            rsp_dz_r    <= bus.div_zero;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= hot_r;
            state_r     <= ST_RESP;
          end else if (wdog_r == WD_W'(TIMEOUT - 1)) begin
            rsp_q_r     <= DIV_SAT;
            rsp_r_r     <= div_a_r;
            rsp_dz_r    <= 1'b0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= hot_r;
            state_r     <= ST_RESP;
          end else begin
            wdog_r      <= wdog_r + WD_W'(1);
          end
        end

        ST_RESP: begin
          rsp_valid_r <= '0;
          ptr_r       <= IDX_W'(rr_next(int'(idx_r), N_REQ));
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end

        default: begin
          gnt_r       <= '0;
          rsp_valid_r <= '0;
          div_start_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_q     = rsp_q_r;
  assign bus.rsp_r     = rsp_r_r;
  assign bus.rsp_dz    = rsp_dz_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.div_start = div_start_r;
  assign bus.div_a     = div_a_r;
  assign bus.div_b     = div_b_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus randomized
// traffic, with a behavioural divider and a round-robin reference model.
module tb_div_arbiter;

  localparam int N  = 4;
  localparam int TO = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  div_arbiter_if #(.N_REQ(N)) bus ();

  div_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compares  = 0;
  int fails     = 0;
  int model_ptr = 0;
  int start_cnt = 0;
  int lat_cfg   = 3;
  bit level_cfg = 1'b0;
  bit hang_cfg  = 1'b0;

  logic [7:0] op_a [N];
  logic [7:0] op_b [N];

  // Divider model: keeps a stale done for one cycle after a start, then
  // reports a/b after lat_cfg cycles; b==0 gives FF / a / zero.
  logic [7:0] m_a, m_b;
  logic       pend;
  int         cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.div_done <= 1'b0;
      bus.div_q    <= 8'd0;
      bus.div_r    <= 8'd0;
      bus.div_zero <= 1'b0;
      pend         <= 1'b0;
      cnt          <= 0;
      m_a          <= 8'd0;
      m_b          <= 8'd0;
    end else if (bus.div_start === 1'b1) begin
      m_a  <= bus.div_a;
      m_b  <= bus.div_b;
      pend <= 1'b1;
    end else if (pend) begin
      pend         <= 1'b0;
      bus.div_done <= 1'b0;
      cnt          <= hang_cfg ? 0 : lat_cfg;
    end else if (cnt == 1) begin
      cnt          <= 0;
      bus.div_done <= 1'b1;
      if (m_b == 8'd0) begin
        bus.div_q    <= 8'hFF;
        bus.div_r    <= m_a;
        bus.div_zero <= 1'b1;
      end else begin
        bus.div_q    <= m_a / m_b;
        bus.div_r    <= m_a % m_b;
        bus.div_zero <= 1'b0;
      end
    end else begin
      if (cnt > 1) cnt <= cnt - 1;
      if (!level_cfg) bus.div_done <= 1'b0;
    end
  end

  // Counts start pulses seen by the divider.
  always @(posedge clk) begin
    if (bus.div_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  // Expected {q, r, dz, err} for one operation.
  function automatic logic [31:0] expect_rsp(input logic [7:0] a, input logic [7:0] b, input bit hang);
    if (hang)           return {14'd0, 8'hFF, a, 1'b0, 1'b1};
    else if (b == 8'd0) return {14'd0, 8'hFF, a, 1'b1, 1'b0};
    else                return {14'd0, 8'(a / b), 8'(a % b), 1'b0, 1'b0};
  endfunction

  task automatic put_op(input int k, input logic [7:0] a, input logic [7:0] b);
    op_a[k] = a;
    op_b[k] = b;
    bus.req_a[k*8 +: 8] = a;
    bus.req_b[k*8 +: 8] = b;
  endtask

  // One full transaction starting from an IDLE cycle, called at a negedge.
  task automatic do_txn(input logic [N-1:0] r, input bit drop);
    int k, c, s0;
    logic [7:0]  a, b;
    logic [31:0] e;
    bit byp;
    k   = pick(r, model_ptr);
    a   = op_a[k];
    b   = op_b[k];
    byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    byp = (b == 8'd0);
`endif
    e  = expect_rsp(a, b, hang_cfg && !byp);
    s0 = start_cnt;
    bus.req = r;
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'd1 << k);
    chk("div_a", 32'(bus.div_a), 32'(a));
    chk("div_b", 32'(bus.div_b), 32'(b));
    chk("busy_on", 32'(bus.busy), 32'd1);
    chk("div_start", 32'(bus.div_start), byp ? 32'd0 : 32'd1);
    if (drop) bus.req = '0;
    else put_op(k, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.rsp_valid == '0 && c < TO + 20);
    chk("rsp_seen", 32'(bus.rsp_valid != '0), 32'd1);
    if (byp) chk("byp_lat", 32'(c), 32'd1);
    else if (hang_cfg) chk("wdog_lat", 32'(c), 32'(TO + 1));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << k);
    chk("rsp", {14'd0, bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_err}, e);
    chk("starts", 32'(start_cnt - s0), byp ? 32'd0 : 32'd1);
    model_ptr = (k + 1) % N;
    @(negedge clk);
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("busy_off", 32'(bus.busy), 32'd0);
    chk("rsp_hold", {14'd0, bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_err}, e);
  endtask

  initial begin
    int seen;
    logic [N-1:0] rr;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < N; i++) put_op(i, 8'd0, 8'd1);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_start", 32'(bus.div_start), 32'd0);
    chk("rst_ops", {16'd0, bus.div_a, bus.div_b}, 32'd0);
    chk("rst_rsp", {14'd0, bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single requester 100/7
    put_op(0, 8'd100, 8'd7);
    do_txn(4'b0001, 1'b1);
    chk("single_q", 32'(bus.rsp_q), 32'd14);
    chk("single_r", 32'(bus.rsp_r), 32'd2);

    // Divide by zero 9/0
    put_op(3, 8'd9, 8'd0);
    do_txn(4'b1000, 1'b1);

    // Watchdog, then normal service on the same requester
    hang_cfg = 1'b1;
    put_op(1, 8'd50, 8'd5);
    do_txn(4'b0010, 1'b1);
    hang_cfg = 1'b0;
    put_op(1, 8'd60, 8'd7);
    do_txn(4'b0010, 1'b1);

    // Level done held across back-to-back requests
    level_cfg = 1'b1;
    lat_cfg   = 2;
    put_op(1, 8'd200, 8'd9);
    put_op(2, 8'd77, 8'd10);
    do_txn(4'b0010, 1'b1);
    do_txn(4'b0100, 1'b1);
    chk("level_q2", 32'(bus.rsp_q), 32'd7);
    level_cfg = 1'b0;

    // Reset during WAIT
    lat_cfg = 12;
    put_op(2, 8'd50, 8'd3);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("mid_gnt", 32'(bus.gnt), 32'd4);
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_rspv", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen++;
    end
    chk("no_stray_rsp", 32'(seen), 32'd0);
    model_ptr = 0;

    // Contention: all requesters held high, grants rotate from 0
    lat_cfg = 3;
    for (int i = 0; i < N; i++) put_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    for (int t = 0; t < 2 * N; t++) do_txn(4'b1111, 1'b0);
    bus.req = '0;
    @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      lat_cfg   = $urandom_range(1, 8);
      level_cfg = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        put_op(i, 8'($urandom_range(0, 255)),
               ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      rr = 4'($urandom_range(1, 15));
      do_txn(rr, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
